unidade_execucao: RTL and testbench
===================================

Name: unidade_execucao

Overview:
- Multicycle decode/execute sequencer that sits directly upstream of the 16x16 register bank and owns its read-address, write-address, write-data and write-enable inputs.
- Accepts one 16-bit instruction per valid/ready handshake and drives the two operand addresses.
- Computes the result in an internal ALU and issues a single-cycle write back into the bank.
- Every instruction takes a fixed 4 cycles, from accept to the end of writeback.

Parameters:
- LARGURA_DADO, 16, data width of operands and result; must match the bank word width.
- LARGURA_END, 4, register address width; must match the bank depth (16 registers).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- instr  input  16  instruction word.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  block can accept an instruction.
- endereco_reg1  output  4  bank read address A (rs1).
- endereco_reg2  output  4  bank read address B (rs2).
- conteudo_reg1  input  16  bank async read data A.
- conteudo_reg2  input  16  bank async read data B.
- endereco_escrita  output  4  bank write address (rd).
- conteudo_escrita  output  16  bank write data.
- enable_escrita  output  1  bank write enable.
- flag_zero  output  1  last ALU result was zero.
- flag_carry  output  1  carry out (ADD) / borrow (SUB) of last ALU op.
- erro_instr  output  1  one-cycle pulse on illegal opcode.

Behaviour:
- Instruction format: op = instr[15:12], rd = instr[11:8], rs1 = instr[7:4], rs2 = instr[3:0], imm8 = instr[7:0].
- Opcodes:
  - 0x0 ADD rd = rs1 + rs2.
  - 0x1 SUB rd = rs1 - rs2.
  - 0x2 AND.
  - 0x3 OR.
  - 0x4 XOR.
  - 0x5 SHL rd = rs1 << rs2[3:0].
  - 0x6 SHR, logical, rd = rs1 >> rs2[3:0].
  - 0x7 LDI rd = {8'h00, imm8}.
  - 0x8 MOV rd = rs1.
  - 0xF NOP, no write.
  - 0x9–0xE illegal.
- Arithmetic is modulo 2^16.
  - ADD: carry = bit 16 of the 17-bit sum.
  - SUB: carry = 1 when rs1 < rs2 (unsigned borrow).
  - Ops 0x2–0x6 clear carry.
- Flags update only for ops 0x0–0x6, at the EXECUTA edge; zero = (result == 0). All other ops hold both flags.
- FSM states: IDLE, LEITURA, EXECUTA, ESCRITA.
  - IDLE: instr_ready = 1 (combinational, only in IDLE). On instr_valid & instr_ready at edge E0: latch instr into the instruction register; go to LEITURA.
  - LEITURA: endereco_reg1/2 come from the latched rs1/rs2. At edge E1: latch conteudo_reg1/2 into operand registers; go to EXECUTA.
  - EXECUTA: at edge E2: latch the ALU result into the result register (drives conteudo_escrita); update flags; go to ESCRITA.
  - ESCRITA: enable_escrita = 1 for exactly this cycle, only for ops 0x0–0x8. The bank writes at edge E3. For 0x9–0xE, erro_instr = 1 this cycle and enable_escrita = 0. At E3 go to IDLE.
- Throughput: one instruction per 4 cycles; instr_ready is low for 3 cycles after each accept.
- Read-after-write: the next instruction's LEITURA follows E3 at the earliest, so it always sees the previous write. No forwarding is required.
- instr_valid or instr changes outside IDLE are ignored. A held valid is accepted on the next IDLE cycle.
- endereco_reg1/2 and endereco_escrita are driven from the instruction register at all times. They hold their last value in IDLE.
- enable_escrita and erro_instr are decoded from state, never registered a cycle late.
- Reset (rst_n = 0, at any time including mid-instruction):
  - FSM goes to IDLE immediately.
  - All registers are cleared: instruction, operands, result, flags.
  - All outputs are 0 except instr_ready = 1. enable_escrita drops within the same cycle.
  - An in-flight instruction is discarded and never written.

Test Plan:
- Reset: assert rst_n = 0 during ESCRITA of an ADD -> enable_escrita falls asynchronously, no bank write. After release, all outputs are 0 and instr_ready = 1.
- LDI: instr = 0x73A5 accepted at E0 -> enable_escrita high only in the cycle after E2, endereco_escrita = 3, conteudo_escrita = 0x00A5. Flags unchanged.
- ADD overflow: r2 = 0xFFFF, r3 = 0x0001, instr = 0x0123 -> write r1 = 0x0000, flag_zero = 1, flag_carry = 1.
- SUB borrow: r5 = 3, r6 = 5, instr = 0x1456 -> write r4 = 0xFFFE, flag_zero = 0, flag_carry = 1. Then SHR with r7 = 0x8000 and r8 = 15 (instr 0x6978) -> r9 = 0x0001, carry = 0.
- Back-to-back with instr_valid held high: 0x7105 then 0x0211 -> accepts exactly 4 cycles apart, instr_ready low for 3 cycles between them; the second instruction reads r1 = 5 and writes r2 = 0x000A.
- Illegal/NOP: 0xA123 -> erro_instr pulses 1 cycle in ESCRITA, enable_escrita stays 0, flags unchanged. 0xF000 -> no write, no error, 4-cycle cadence kept.

Source files
------------

// File: rtl/unidade_execucao_if.sv
// Instruction handshake and register-bank port bundle for unidade_execucao.
// The sequencer uses the slave side; the bank/issue environment uses the master side.
interface unidade_execucao_if #(
    parameter int unsigned LARGURA_DADO = 16,
    parameter int unsigned LARGURA_END  = 4
);
    logic [15:0]             instr;
    logic                    instr_valid;
    logic                    instr_ready;
    logic [LARGURA_END-1:0]  endereco_reg1;
    logic [LARGURA_END-1:0]  endereco_reg2;
    logic [LARGURA_DADO-1:0] conteudo_reg1;
    logic [LARGURA_DADO-1:0] conteudo_reg2;
    logic [LARGURA_END-1:0]  endereco_escrita;
    logic [LARGURA_DADO-1:0] conteudo_escrita;
    logic                    enable_escrita;
    logic                    flag_zero;
    logic                    flag_carry;
    logic                    erro_instr;

    modport slave (
        input  instr, instr_valid, conteudo_reg1, conteudo_reg2,
        output instr_ready, endereco_reg1, endereco_reg2, endereco_escrita,
        output conteudo_escrita, enable_escrita, flag_zero, flag_carry, erro_instr
    );

    modport master (
        output instr, instr_valid, conteudo_reg1, conteudo_reg2,
        input  instr_ready, endereco_reg1, endereco_reg2, endereco_escrita,
        input  conteudo_escrita, enable_escrita, flag_zero, flag_carry, erro_instr
    );
endinterface

// File: rtl/unidade_execucao.sv
// Four-cycle decode/execute sequencer driving a 16x16 register bank:
// fetch operands, run the ALU, then issue one write-back cycle.
module unidade_execucao #(
    parameter int unsigned LARGURA_DADO = 16,
    parameter int unsigned LARGURA_END  = 4
) (
    input logic                clk,
    input logic                rst_n,
    unidade_execucao_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StLeitura, StExecuta, StEscrita} estado_e;

    localparam logic [3:0] OpAdd = 4'h0;
    localparam logic [3:0] OpSub = 4'h1;
    localparam logic [3:0] OpAnd = 4'h2;
    localparam logic [3:0] OpOr  = 4'h3;
    localparam logic [3:0] OpXor = 4'h4;
    localparam logic [3:0] OpShl = 4'h5;
    localparam logic [3:0] OpShr = 4'h6;
    localparam logic [3:0] OpLdi = 4'h7;
    localparam logic [3:0] OpMov = 4'h8;
    localparam logic [3:0] OpNop = 4'hF;

    estado_e                 estado_q, estado_d;
    logic [15:0]             instr_q, instr_d;
    logic [LARGURA_DADO-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [LARGURA_DADO-1:0] result_q, result_d;
    logic                    zero_q, zero_d, carry_q, carry_d;

    logic [3:0]              opcode;
    logic [LARGURA_DADO:0]   soma;
    logic [LARGURA_DADO-1:0] alu_res;
    logic                    alu_carry;
    logic                    op_escreve, op_ilegal, op_flags;

    assign opcode     = instr_q[15:12];
    assign op_escreve = (opcode <= OpMov);
    assign op_ilegal  = (opcode > OpMov) && (opcode != OpNop);
    assign op_flags   = (opcode <= OpShr);

    always_comb begin
        soma      = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        case (opcode)
            OpAdd: begin
                soma      = {1'b0, op_a_q} + {1'b0, op_b_q};
                alu_res   = soma[LARGURA_DADO-1:0];
                alu_carry = soma[LARGURA_DADO];
            end
            // The extra top bit of the widened difference is the unsigned borrow.
            OpSub: begin
                soma      = {1'b0, op_a_q} - {1'b0, op_b_q};
                alu_res   = soma[LARGURA_DADO-1:0];
                alu_carry = soma[LARGURA_DADO];
            end
            OpAnd:   alu_res = op_a_q & op_b_q;
            OpOr:    alu_res = op_a_q | op_b_q;
            OpXor:   alu_res = op_a_q ^ op_b_q;
            OpShl:   alu_res = op_a_q << op_b_q[3:0];
            OpShr:   alu_res = op_a_q >> op_b_q[3:0];
            OpLdi:   alu_res = {{(LARGURA_DADO-8){1'b0}}, instr_q[7:0]};
            OpMov:   alu_res = op_a_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        estado_d = estado_q;
        instr_d  = instr_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        case (estado_q)
            StIdle: begin
                if (bus.instr_valid) begin
                    instr_d  = bus.instr;
                    estado_d = StLeitura;
                end
            end
            StLeitura: begin
                op_a_d   = bus.conteudo_reg1;
                op_b_d   = bus.conteudo_reg2;
                estado_d = StExecuta;
            end
            StExecuta: begin
                result_d = alu_res;
                if (op_flags) begin
                    zero_d  = (alu_res == '0);
                    carry_d = alu_carry;
                end
                estado_d = StEscrita;
            end
            default: estado_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= StIdle;
            instr_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            instr_q  <= instr_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    // Strobes decode straight from state so reset kills a pending write at once.
    assign bus.instr_ready      = (estado_q == StIdle);
    assign bus.enable_escrita   = (estado_q == StEscrita) && op_escreve;
    assign bus.erro_instr       = (estado_q == StEscrita) && op_ilegal;
    assign bus.endereco_reg1    = instr_q[7:4];
    assign bus.endereco_reg2    = instr_q[3:0];
    assign bus.endereco_escrita = instr_q[11:8];
    assign bus.conteudo_escrita = result_q;
    assign bus.flag_zero        = zero_q;
    assign bus.flag_carry       = carry_q;
endmodule

// File: tb/tb_unidade_execucao.sv
// Bench for unidade_execucao: a behavioural register bank plus an arithmetic
// reference model of the instruction set, driven by directed and random instructions.
module tb_unidade_execucao;
    logic clk;
    logic rst_n;

    unidade_execucao_if #(.LARGURA_DADO(16), .LARGURA_END(4)) bus ();

    unidade_execucao #(.LARGURA_DADO(16), .LARGURA_END(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] bank [16];
    logic        poke_en;
    logic [3:0]  poke_addr;
    logic [15:0] poke_data;

    assign bus.conteudo_reg1 = bank[bus.endereco_reg1];
    assign bus.conteudo_reg2 = bank[bus.endereco_reg2];

    always @(posedge clk) begin
        if (poke_en) bank[poke_addr] <= poke_data;
        else if (bus.enable_escrita) bank[bus.endereco_escrita] <= bus.conteudo_escrita;
    end

    logic [15:0] mdl [16];
    logic        mdl_z, mdl_c;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic poke(input logic [3:0] a, input logic [15:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk); @(negedge clk);
        poke_en = 1'b0;
        mdl[a] = d;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_ready", 32'(bus.instr_ready), 1);
        check_eq("rst_we", 32'(bus.enable_escrita), 0);
        check_eq("rst_err", 32'(bus.erro_instr), 0);
        check_eq("rst_flags", {30'd0, bus.flag_zero, bus.flag_carry}, 0);
        check_eq("rst_addr", {20'd0, bus.endereco_reg1, bus.endereco_reg2, bus.endereco_escrita}, 0);
        check_eq("rst_wdata", 32'(bus.conteudo_escrita), 0);
    endtask

    task automatic scramble();
        bus.instr       = 16'($urandom);
        bus.instr_valid = 1'($urandom);
    endtask

    // Issues one instruction from IDLE and follows it through all four cycles.
    task automatic run_instr(input logic [15:0] ins, input bit hold);
        logic [3:0] op, rd, rs1, rs2;
        int unsigned a, b, r;
        bit c, wr, er;
        op = ins[15:12]; rd = ins[11:8]; rs1 = ins[7:4]; rs2 = ins[3:0];
        a = mdl[rs1]; b = mdl[rs2]; r = 0; c = 1'b0;
        case (op)
            4'h0: begin r = a + b; c = (r > 32'hFFFF); end
            4'h1: begin r = a - b; c = (a < b); end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = a << (b % 16);
            4'h6: r = a >> (b % 16);
            4'h7: r = ins[7:0];
            4'h8: r = a;
            default: r = 0;
        endcase
        r  = r & 32'hFFFF;
        wr = (op <= 4'h8);
        er = (op >= 4'h9) && (op <= 4'hE);

        check_eq("ready_idle", 32'(bus.instr_ready), 1);
        bus.instr = ins; bus.instr_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        if (!hold) scramble();
        check_eq("ready_leitura", 32'(bus.instr_ready), 0);
        check_eq("rd_addr1", 32'(bus.endereco_reg1), 32'(rs1));
        check_eq("rd_addr2", 32'(bus.endereco_reg2), 32'(rs2));
        check_eq("we_leitura", 32'(bus.enable_escrita), 0);
        @(posedge clk); @(negedge clk);
        if (!hold) scramble();
        check_eq("ready_executa", 32'(bus.instr_ready), 0);
        check_eq("we_executa", {31'd0, bus.enable_escrita | bus.erro_instr}, 0);
        @(posedge clk); @(negedge clk);
        if (!hold) scramble();
        if (op <= 4'h6) begin mdl_z = (r == 0); mdl_c = c; end
        check_eq("ready_escrita", 32'(bus.instr_ready), 0);
        check_eq("we_escrita", 32'(bus.enable_escrita), 32'(wr));
        check_eq("err_escrita", 32'(bus.erro_instr), 32'(er));
        check_eq("wr_addr", 32'(bus.endereco_escrita), 32'(rd));
        check_eq("flags", {30'd0, bus.flag_zero, bus.flag_carry}, {30'd0, mdl_z, mdl_c});
        if (wr) begin
            check_eq("wr_data", 32'(bus.conteudo_escrita), r);
            mdl[rd] = r[15:0];
        end
        @(posedge clk); @(negedge clk);
        if (!hold) bus.instr_valid = 1'b0;
        check_eq("we_after", {31'd0, bus.enable_escrita | bus.erro_instr}, 0);
        check_eq("wr_addr_hold", 32'(bus.endereco_escrita), 32'(rd));
    endtask

    initial begin
        rst_n = 1'b0; bus.instr = '0; bus.instr_valid = 1'b0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        mdl_z = 1'b0; mdl_c = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        for (int i = 0; i < 16; i++) poke(4'(i), 16'($urandom));

        // Directed cases
        run_instr(16'h73A5, 1'b0);
        poke(4'd2, 16'hFFFF); poke(4'd3, 16'h0001);
        run_instr(16'h0123, 1'b0);
        check_eq("add_ovf_zc", {30'd0, bus.flag_zero, bus.flag_carry}, 3);
        poke(4'd5, 16'd3); poke(4'd6, 16'd5);
        run_instr(16'h1456, 1'b0);
        check_eq("sub_r4", 32'(bank[4]), 32'hFFFE);
        poke(4'd7, 16'h8000); poke(4'd8, 16'd15);
        run_instr(16'h6978, 1'b0);
        check_eq("shr_r9", 32'(bank[9]), 32'h0001);
        run_instr(16'h7105, 1'b1);
        run_instr(16'h0211, 1'b1);
        bus.instr_valid = 1'b0;
        check_eq("b2b_r2", 32'(bank[2]), 32'h000A);
        run_instr(16'hA123, 1'b0);
        run_instr(16'hF000, 1'b0);

        // Reset during the write-back cycle of an ADD must discard the write.
        poke(4'd10, 16'd7); poke(4'd11, 16'd9); poke(4'd12, 16'h1234);
        bus.instr = 16'h0CAB; bus.instr_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.instr_valid = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        check_eq("rst_we_before", 32'(bus.enable_escrita), 1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_we_async", 32'(bus.enable_escrita), 0);
        @(posedge clk); @(negedge clk);
        check_eq("rst_no_write", 32'(bank[12]), 32'h1234);
        check_reset_outputs();
        rst_n = 1'b1; mdl_z = 1'b0; mdl_c = 1'b0;
        @(negedge clk);
        check_reset_outputs();

        for (int i = 0; i < 60; i++) run_instr(16'($urandom), 1'b0);
        for (int i = 0; i < 16; i++) check_eq("bank_final", 32'(bank[i]), 32'(mdl[i]));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
